std_fp_div_pipe: RTL and testbench



---
 rtl/std_fp_div_pipe.sv | 133 +++++++++++++
 tb/tb_std_fp_div_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/std_fp_div_pipe.sv
// Unsigned fixed-point divider: quotient = (left << FRAC_WIDTH) / right by restoring long division,
// one quotient bit per clock, with the go/done handshake used by the other multi-cycle primitives.
module std_fp_div_pipe #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int N  = WIDTH + FRAC_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH != INT_WIDTH + FRAC_WIDTH) begin : g_bad_format
    $error("std_fp_div_pipe: WIDTH must equal INT_WIDTH + FRAC_WIDTH");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     dividend_q, dividend_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] out_quot_q, out_quot_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quot_next;

  // One restoring step. The quotient register keeps only the low WIDTH bits, so
  // higher quotient bits fall off the top, giving the wrap-around on overflow.
  always_comb begin
    shifted   = (rem_q << 1) | (WIDTH + 1)'(dividend_q[N-1]);
    diff      = shifted - {1'b0, divisor_q};
    fits      = (shifted >= {1'b0, divisor_q});
    rem_next  = fits ? diff : shifted;
    quot_next = (quot_q << 1) | WIDTH'(fits);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    left_d     = left_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          dividend_d = {left, {FRAC_WIDTH{1'b0}}};
          divisor_d  = right;
          left_d     = left;
          quot_d     = '0;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        dividend_d = dividend_q << 1;
        quot_d     = quot_next;
        rem_d      = rem_next;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Divide by zero keeps the normal latency but reports a fixed result.
          if (divisor_q == '0) begin
            out_quot_d = '1;
            out_rem_d  = left_q;
          end else begin
            out_quot_d = quot_next;
            out_rem_d  = WIDTH'(rem_next);
          end
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      left_q     <= '0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      left_q     <= left_d;
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      done_q     <= done_d;
    end
  end

  assign out_quotient  = out_quot_q;
  assign out_remainder = out_rem_q;
  assign done          = done_q;

endmodule

// File: tb/tb_std_fp_div_pipe.sv
// Self-checking bench for std_fp_div_pipe: directed cases plus random operands
// compared against a plain-arithmetic model of (left << 16) / right.
module tb_std_fp_div_pipe;

  logic        clk;
  logic        reset;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] outQuotient;
  logic [31:0] outRemainder;
  logic        done;

  int checks;
  int failures;

  std_fp_div_pipe #(
    .WIDTH(32),
    .INT_WIDTH(16),
    .FRAC_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .left(left),
    .right(right),
    .out_quotient(outQuotient),
    .out_remainder(outRemainder),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: full-precision integer division, truncated to 32 bits.
  function automatic logic [63:0] refDiv(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] num;
    logic [63:0] q;
    logic [63:0] rm;
    num = {16'h0, l, 16'h0};
    if (r == 32'h0) return {32'hFFFF_FFFF, l};
    q  = num / {32'h0, r};
    rm = num % {32'h0, r};
    return {q[31:0], rm[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; that cycle is cycle 1 of the operation. Returns at the
  // negedge of cycle 51, having checked the done cycle, the results and the hold.
  task automatic applyStimulus(input string tag, input logic [31:0] l, input logic [31:0] r,
                               input bit holdGo, input bit chain,
                               input logic [31:0] expQ, input logic [31:0] expR);
    int cyc;
    bit seen;
    left  = l;
    right = r;
    go    = 1'b1;
    cyc   = 1;
    seen  = 1'b0;
    while (!seen && cyc <= 60) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (cyc == 1) begin
          left  = $urandom;
          right = $urandom;
          if (!holdGo) go = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " done_cycle"}, 64'(cyc), 64'd50);
    checkOutput({tag, " quotient"}, 64'(outQuotient), 64'(expQ));
    checkOutput({tag, " remainder"}, 64'(outRemainder), 64'(expR));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " done_single_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, " quotient_hold"}, 64'(outQuotient), 64'(expQ));
    if (!chain) go = 1'b0;
  endtask

  initial begin
    logic [63:0] expected;
    logic [31:0] l;
    logic [31:0] r;
    int doneHighs;
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    go    = 1'b0;
    left  = 32'h0;
    right = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset quotient", 64'(outQuotient), 64'd0);
    checkOutput("reset remainder", 64'(outRemainder), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);

    applyStimulus("3.0/2.0", 32'h0003_0000, 32'h0002_0000, 1'b1, 1'b0, 32'h0001_8000, 32'h0);
    applyStimulus("1.0/3.0", 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0, 32'h0000_5555, 32'h0001_0000);
    applyStimulus("div_zero", 32'h0005_0000, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0005_0000);
    applyStimulus("overflow", 32'hFFFF_0000, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus("zero_left", 32'h0, 32'h0001_2345, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 6; i++) begin
      l = $urandom;
      case (i % 3)
        0:       r = $urandom;
        1:       r = 32'($urandom_range(1, 255));
        default: r = {16'h0, 16'($urandom)} | 32'h1;
      endcase
      if (i == 5) r = 32'h0;
      expected = refDiv(l, r);
      applyStimulus($sformatf("random%0d", i), l, r, 1'b0, 1'b0, expected[63:32], expected[31:0]);
    end

    // Reset in cycle 20 of an operation must abort it and clear the outputs.
    left  = 32'h0007_0000;
    right = 32'h0003_0000;
    go    = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (18) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset quotient", 64'(outQuotient), 64'd0);
    checkOutput("midreset remainder", 64'(outRemainder), 64'd0);
    doneHighs = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) doneHighs++;
      @(negedge clk);
    end
    checkOutput("midreset no_done", 64'(doneHighs), 64'd0);
    applyStimulus("after_reset 3.0/2.0", 32'h0003_0000, 32'h0002_0000, 1'b0, 1'b0, 32'h0001_8000, 32'h0);

    applyStimulus("b2b first 6.0/2.0", 32'h0006_0000, 32'h0002_0000, 1'b1, 1'b1, 32'h0003_0000, 32'h0);
    applyStimulus("b2b second 1.0/4.0", 32'h0001_0000, 32'h0004_0000, 1'b1, 1'b0, 32'h0000_4000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
